// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between port A (CPU) and port B (DMA/debug), round-robin with optional burst lock.
// Latency: combinational grant; memory ports registered (accept+1); read data and rvalid at accept+2.
// Backpressure: a port waits with req held until gnt; no accept in a cycle leaves the memory strobes low.
// Optional feature: define MEM_ARB_BURST_EN to let an owner keep the grant for up to MAX_BURST consecutive accesses.
module data_mem_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    // Burst count saturates at the limit so a long solo stream never wraps back under it.
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t     state, state_nxt, win;
    logic       last_b, last_nxt;   // 1 = port B was served last
    logic [3:0] bcnt, bcnt_nxt;
    logic       pick_b;
    logic       tag_b;              // port that owns the access currently on the memory port

    // Arbitration: choose winner, raise its grant, compute next owner/last/burst count.
    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        pick_b    = 1'b0;
        win       = IDLE;
        state_nxt = state;
        last_nxt  = last_b;
        bcnt_nxt  = bcnt;
        if (a_req && b_req) begin
`ifdef MEM_ARB_BURST_EN
            if (state == OWN_A && bcnt < BURST_MAX)
                pick_b = 1'b0;
            else if (state == OWN_B && bcnt < BURST_MAX)
                pick_b = 1'b1;
            else
                pick_b = ~last_b;
`else
            pick_b = ~last_b;
`endif
        end else begin
            pick_b = b_req;
        end
        if (!rst && (a_req || b_req)) begin
            a_gnt     = ~pick_b;
            b_gnt     = pick_b;
            last_nxt  = pick_b;
            win       = pick_b ? OWN_B : OWN_A;
            state_nxt = win;
            if (state == win)
                bcnt_nxt = (bcnt >= BURST_MAX) ? BURST_MAX : bcnt + 4'd1;
            else
                bcnt_nxt = 4'd1;
        end else if (!rst) begin
            state_nxt = IDLE;
            bcnt_nxt  = 4'd0;
        end
    end

    // Owner state, last-served pointer and burst count; B counts as last after reset so A wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_b <= 1'b1;
            bcnt   <= 4'd0;
        end else begin
            state  <= state_nxt;
            last_b <= last_nxt;
            bcnt   <= bcnt_nxt;
        end
    end

    // Memory port registers: latch the accepted request; strobes drop when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_access_addr <= '0;
            mem_write_data  <= '0;
            mem_write_en    <= 1'b0;
            mem_read        <= 1'b0;
            tag_b           <= 1'b0;
        end else if (a_gnt || b_gnt) begin
            mem_access_addr <= b_gnt ? b_addr  : a_addr;
            mem_write_data  <= b_gnt ? b_wdata : a_wdata;
            mem_write_en    <= b_gnt ? b_we    : a_we;
            mem_read        <= b_gnt ? ~b_we   : ~a_we;
            tag_b           <= b_gnt;
        end else begin
            mem_write_en    <= 1'b0;
            mem_read        <= 1'b0;
        end
    end

    // Read return: capture memory data into the tagged port and pulse its rvalid; reset drops a pending return.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= mem_read & ~tag_b;
            b_rvalid <= mem_read & tag_b;
            if (mem_read && !tag_b)
                a_rdata <= mem_read_data;
            if (mem_read && tag_b)
                b_rdata <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed test-plan sequences, then randomized traffic with reset pulses.
// Outputs are checked every cycle at the falling edge against a transaction-level model.
// Requests are held until granted; a behavioural memory sits on the memory port.
module tb_data_mem_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DATA_W(16), .ADDR_W(16), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    // Behavioural single-port memory (no reset), combinational read.
    logic [15:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    assign mem_read_data = mem[mem_access_addr[7:0]];
    always @(posedge clk) if (mem_write_en) mem[mem_access_addr[7:0]] <= mem_write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        bit          v;
        bit          pb;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] rd;
        bit          rst;
    } rec_t;

    rec_t        p1, p2;
    bit          m_last_b = 1'b1;
    int          m_owner  = 0;      // 0 none, 1 A, 2 B
    int          m_run    = 0;      // consecutive grants to m_owner
    logic [15:0] h_addr = 0, h_wd = 0, h_ard = 0, h_brd = 0;
    logic [15:0] shadow [0:255];

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 16'h0;
        p1 = '{v:0, pb:0, we:0, addr:0, wd:0, rd:0, rst:1};
        p2 = p1;
    end

    // Compare DUT outputs with the model every cycle, then advance the model by one accept.
    always @(negedge clk) begin
        bit   ea, eb, ewe, erd, eav, ebv, pick;
        rec_t cur;
        ewe = 0; erd = 0; eav = 0; ebv = 0; ea = 0; eb = 0; pick = 0;
        if (p1.rst) begin
            h_addr = 0; h_wd = 0; h_ard = 0; h_brd = 0;
        end else if (p1.v) begin
            h_addr = p1.addr; h_wd = p1.wd; ewe = p1.we; erd = !p1.we;
            if (p2.v && !p2.we) begin
                if (p2.pb) begin ebv = 1; h_brd = p2.rd; end
                else begin eav = 1; h_ard = p2.rd; end
            end
        end else if (p2.v && !p2.we) begin
            if (p2.pb) begin ebv = 1; h_brd = p2.rd; end
            else begin eav = 1; h_ard = p2.rd; end
        end
        if (!rst && (a_req || b_req)) begin
            if (a_req && b_req) begin
                pick = !m_last_b;
`ifdef MEM_ARB_BURST_EN
                if (m_owner != 0 && m_run < MAXB) pick = (m_owner == 2);
`endif
            end else begin
                pick = b_req;
            end
            ea = !pick; eb = pick;
        end
        chk("a_gnt", 32'(a_gnt), 32'(ea));
        chk("b_gnt", 32'(b_gnt), 32'(eb));
        chk("mem_write_en", 32'(mem_write_en), 32'(ewe));
        chk("mem_read", 32'(mem_read), 32'(erd));
        chk("mem_access_addr", 32'(mem_access_addr), 32'(h_addr));
        chk("mem_write_data", 32'(mem_write_data), 32'(h_wd));
        chk("a_rvalid", 32'(a_rvalid), 32'(eav));
        chk("b_rvalid", 32'(b_rvalid), 32'(ebv));
        chk("a_rdata", 32'(a_rdata), 32'(h_ard));
        chk("b_rdata", 32'(b_rdata), 32'(h_brd));

        cur = '{v:0, pb:0, we:0, addr:0, wd:0, rd:0, rst:rst};
        if (rst) begin
            m_last_b = 1; m_owner = 0; m_run = 0;
        end else if (ea || eb) begin
            cur.v    = 1;
            cur.pb   = eb;
            cur.we   = eb ? b_we : a_we;
            cur.addr = eb ? b_addr : a_addr;
            cur.wd   = eb ? b_wdata : a_wdata;
            cur.rd   = shadow[cur.addr[7:0]];
            if (cur.we) shadow[cur.addr[7:0]] = cur.wd;
            if (m_owner == (eb ? 2 : 1)) m_run++;
            else begin m_owner = eb ? 2 : 1; m_run = 1; end
            m_last_b = eb;
        end else begin
            m_owner = 0; m_run = 0;
        end
        p2 = p1;
        p1 = cur;
    end

    // ---------------- stimulus ----------------
    task automatic tick; @(posedge clk); #1; endtask
    task automatic mid;  @(negedge clk); endtask

    task automatic drv_a(input logic r, input logic w, input logic [15:0] ad, input logic [15:0] d);
        a_req = r; a_we = w; a_addr = ad; a_wdata = d;
    endtask
    task automatic drv_b(input logic r, input logic w, input logic [15:0] ad, input logic [15:0] d);
        b_req = r; b_we = w; b_addr = ad; b_wdata = d;
    endtask

    initial begin
        logic [7:0] seq;
        bit a_done, b_done;
        rst = 1;
        drv_a(1, 1, 16'd3, 16'h1234);
        drv_b(0, 0, 16'd0, 16'h0);
        tick; tick;
        mid;
        chk("reset_a_gnt", 32'(a_gnt), 32'd0);
        chk("reset_mem_write_en", 32'(mem_write_en), 32'd0);
        chk("reset_a_rdata", 32'(a_rdata), 32'd0);

        // A writes 0x1234 to addr 3, then reads it back.
        tick; rst = 0;
        mid;  chk("s1_c0_a_gnt", 32'(a_gnt), 32'd1);
        tick; drv_a(1, 0, 16'd3, 16'h0);
        mid;  chk("s1_c1_a_gnt", 32'(a_gnt), 32'd1);
              chk("s1_c1_mem_write_en", 32'(mem_write_en), 32'd1);
              chk("s1_c1_mem_write_data", 32'(mem_write_data), 32'h1234);
        tick; drv_a(0, 0, 16'd0, 16'h0);
        mid;  chk("s1_c2_a_rvalid", 32'(a_rvalid), 32'd0);
        tick;
        mid;  chk("s1_c3_a_rvalid", 32'(a_rvalid), 32'd1);
              chk("s1_c3_a_rdata", 32'(a_rdata), 32'h1234);

        // A requests first, then both stream reads continuously.
        tick; drv_a(1, 0, 16'd1, 16'h0);
        mid;  chk("s2_first_a_gnt", 32'(a_gnt), 32'd1);
        tick; drv_b(1, 0, 16'd2, 16'h0);
`ifdef MEM_ARB_BURST_EN
        seq = 8'b0111_1000;
`else
        seq = 8'b0101_0101;
`endif
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick;
            mid;
            chk("s2_b_gnt_seq", 32'(b_gnt), 32'(seq[i]));
        end
        tick; drv_a(0, 0, 16'd0, 16'h0); drv_b(0, 0, 16'd0, 16'h0);
        tick; tick; tick;

        // B writes 0x00FF to addr 5, A reads addr 5 the next cycle.
        drv_b(1, 1, 16'd5, 16'h00FF);
        mid;  chk("s3_b_gnt", 32'(b_gnt), 32'd1);
        tick; drv_b(0, 0, 16'd0, 16'h0); drv_a(1, 0, 16'd5, 16'h0);
        tick; drv_a(0, 0, 16'd0, 16'h0);
        tick;
        mid;  chk("s3_a_rvalid", 32'(a_rvalid), 32'd1);
              chk("s3_a_rdata", 32'(a_rdata), 32'h00FF);

        // Reset right after an A read accept.
        tick; drv_a(1, 0, 16'd5, 16'h0);
        mid;  chk("s4_a_gnt", 32'(a_gnt), 32'd1);
        tick; drv_a(0, 0, 16'd0, 16'h0); rst = 1;
        mid;  chk("s4_rst_a_gnt", 32'(a_gnt), 32'd0);
        tick; rst = 0; drv_a(1, 0, 16'd5, 16'h0); drv_b(1, 0, 16'd7, 16'h0);
        mid;  chk("s4_after_a_rvalid", 32'(a_rvalid), 32'd0);
              chk("s4_after_mem_read", 32'(mem_read), 32'd0);
              chk("s4_after_a_rdata", 32'(a_rdata), 32'd0);
              chk("s4_tie_a_gnt", 32'(a_gnt), 32'd1);
              chk("s4_tie_b_gnt", 32'(b_gnt), 32'd0);
        tick; drv_a(0, 0, 16'd0, 16'h0);
        mid;  chk("s4_b_gnt", 32'(b_gnt), 32'd1);
        tick; drv_b(0, 0, 16'd0, 16'h0);
        mid;  chk("s4_a_rdata", 32'(a_rdata), 32'h00FF);
        tick;
        mid;  chk("s5_b_rvalid", 32'(b_rvalid), 32'd1);
              chk("s5_a_rvalid", 32'(a_rvalid), 32'd0);
              chk("s5_a_rdata_held", 32'(a_rdata), 32'h00FF);
              chk("s5_b_rdata", 32'(b_rdata), 32'h0);

        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 1500; c++) begin
            mid;
            a_done = a_req && a_gnt;
            b_done = b_req && b_gnt;
            tick;
            rst = ($urandom_range(0, 59) == 0);
            if (!a_req || a_done)
                drv_a($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                      16'($urandom_range(0, 15)), 16'($urandom));
            if (!b_req || b_done)
                drv_b($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                      16'($urandom_range(0, 15)), 16'($urandom));
        end
        tick; rst = 0; drv_a(0, 0, 16'd0, 16'h0); drv_b(0, 0, 16'd0, 16'h0);
        tick; tick; tick;
        mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
